// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Optional build macro used by this block: IFETCH_PERF_EN (perf counters).
package ifetch_queue_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [XLEN-1:0]    PC_STEP          = 32'd4;
    localparam logic [XLEN-1:0]    DEFAULT_RESET_PC = 32'h0000_0000;
    // Canonical addi x0,x0,0; decode inserts it for bubbles.
    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;

    // One prefetched instruction together with its PC tag.
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Fetch addresses are always word aligned.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Bundle of the fetch stage's memory, decode and redirect handshakes.
// master = fetch stage, slave = memory/decode/branch environment.
// Optional build macro: IFETCH_PERF_EN adds the two perf counter outputs.
interface ifetch_queue_if;
    import ifetch_queue_pkg::*;

    logic               IFreq_valid;
    logic [XLEN-1:0]    IFreq_addr;
    logic               IFreq_ready;
    logic               IFrsp_valid;
    logic [INSTR_W-1:0] IFrsp_data;
    logic               IFout_valid;
    logic [INSTR_W-1:0] IFout_instr;
    logic [XLEN-1:0]    IFout_pc;
    logic               IFout_ready;
    logic               IFredirect;
    logic [XLEN-1:0]    IFredirect_pc;
`ifdef IFETCH_PERF_EN
    logic [31:0]        IFperf_flushes;
    logic [31:0]        IFperf_bubbles;
`endif

    modport master (
        output IFreq_valid,
        output IFreq_addr,
        input  IFreq_ready,
        input  IFrsp_valid,
        input  IFrsp_data,
        output IFout_valid,
        output IFout_instr,
        output IFout_pc,
        input  IFout_ready,
        input  IFredirect,
`ifdef IFETCH_PERF_EN
        output IFperf_flushes,
        output IFperf_bubbles,
`endif
        input  IFredirect_pc
    );

    modport slave (
        input  IFreq_valid,
        input  IFreq_addr,
        output IFreq_ready,
        output IFrsp_valid,
        output IFrsp_data,
        input  IFout_valid,
        input  IFout_instr,
        input  IFout_pc,
        output IFout_ready,
        output IFredirect,
`ifdef IFETCH_PERF_EN
        input  IFperf_flushes,
        input  IFperf_bubbles,
`endif
        output IFredirect_pc
    );

endinterface

// File: rtl/ifetch_queue_fifo.sv
// if_fifo: synchronous DEPTH-entry FIFO of fetch entries with flush and a
// registered head so the decode-facing outputs come straight from flops.
module if_fifo
    import ifetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] count_o,
    output fetch_entry_t     head_o
);

    fetch_entry_t [DEPTH-1:0] mem_q, mem_d;
    fetch_entry_t             head_q, head_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     do_push, do_pop;

    // Next-state: flush beats push/pop; a push into a full queue needs a same-cycle pop.
    always_comb begin
        do_pop   = pop_i && (count_q != '0) && !flush_i;
        do_push  = push_i && !flush_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
        // Look ahead through this cycle's write so a push into an empty queue
        // lands in the head register on the same edge.
        head_d = mem_d[rd_ptr_d];
    end

    // State registers, synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mem_q    <= '0;
            head_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            head_q   <= head_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = head_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: issues sequential word fetches under a credit
// limit, tags returned words with their PC, buffers them in if_fifo and
// hands one per cycle to decode. Redirects flush the queue and discard
// responses still in flight.
// Optional build macro: IFETCH_PERF_EN adds IFperf_flushes / IFperf_bubbles.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic           clk,
    input  logic           reset,
    ifetch_queue_if.master bus
);

    localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;
    localparam int unsigned CREDIT_W = CNT_W + 1;

    logic [XLEN-1:0]     fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]     rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]    inflight_q, inflight_d;
    logic [CNT_W-1:0]    discard_q, discard_d;
    logic [CNT_W-1:0]    count;
    logic [CREDIT_W-1:0] credit_used;
    logic                req_valid, req_fire, rsp_keep;
    fetch_entry_t        push_entry, head;

    // Request/response qualification; queued plus in-flight words may never exceed DEPTH.
    always_comb begin
        credit_used = {1'b0, count} + {1'b0, inflight_q};
        req_valid   = !reset && !bus.IFredirect && (credit_used < CREDIT_W'(DEPTH));
        req_fire    = req_valid && bus.IFreq_ready;
        rsp_keep    = bus.IFrsp_valid && !bus.IFredirect && (discard_q == '0);
        push_entry  = '{pc: rsp_pc_q, instr: bus.IFrsp_data};
    end

    // In-flight and discard accounting; a redirect turns everything still outstanding into discards.
    always_comb begin
        inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(bus.IFrsp_valid);
        discard_d  = discard_q;
        if (bus.IFredirect) begin
            discard_d = inflight_d;
        end else if (bus.IFrsp_valid && (discard_q != '0)) begin
            discard_d = discard_q - CNT_W'(1);
        end
    end

    // Fetch and response PC tracking; both restart at the redirect target.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        if (bus.IFredirect) begin
            fetch_pc_d = align_pc(bus.IFredirect_pc);
            rsp_pc_d   = align_pc(bus.IFredirect_pc);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (rsp_keep) begin
                rsp_pc_d = rsp_pc_q + PC_STEP;
            end
        end
    end

    // Counter and PC registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    if_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .reset_i     (reset),
        .push_i      (rsp_keep),
        .push_data_i (push_entry),
        .pop_i       (bus.IFout_ready),
        .flush_i     (bus.IFredirect),
        .count_o     (count),
        .head_o      (head)
    );

    // Drive the interface outputs.
    always_comb begin
        bus.IFreq_valid = req_valid;
        bus.IFreq_addr  = fetch_pc_q;
        bus.IFout_valid = (count != '0);
        bus.IFout_instr = head.instr;
        bus.IFout_pc    = head.pc;
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] flushes_q, flushes_d;
    logic [31:0] bubbles_q, bubbles_d;

    // Saturating event counters for redirects and empty-output cycles.
    always_comb begin
        flushes_d = flushes_q;
        bubbles_d = bubbles_q;
        if (bus.IFredirect && (flushes_q != '1)) begin
            flushes_d = flushes_q + 32'd1;
        end
        if ((count == '0) && (bubbles_q != '1)) begin
            bubbles_d = bubbles_q + 32'd1;
        end
    end

    // Perf counter registers, cleared on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            flushes_q <= '0;
            bubbles_q <= '0;
        end else begin
            flushes_q <= flushes_d;
            bubbles_q <= bubbles_d;
        end
    end

    assign bus.IFperf_flushes = flushes_q;
    assign bus.IFperf_bubbles = bubbles_q;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: a behavioural memory with variable in-order
// latency plus a queue-level model of what decode must see.
module tb_ifetch_queue;
    import ifetch_queue_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ifetch_queue_if bus ();

    ifetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] dut_addr;
        logic [31:0] mdl_pc;
        int          due;
        bit          stale;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] pop_log[$];
    logic [31:0] mdl_fetch_pc;
    int          cyc, last_due, lat;
    int          vectors, miscompares;
    int          acc_cnt, n_flush, n_bubble;
    logic [31:0] last_acc_addr;

    bit          rst, req_rdy, out_rdy, redir;
    logic [31:0] redir_pc;
    bit          rsp_now, cap_req_valid, cap_out_valid;
    logic [31:0] cap_req_addr, cap_out_pc, cap_out_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    function automatic logic [31:0] log_at(input int i);
        if (i < pop_log.size()) return pop_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, compare after settling, advance model at posedge.
    task automatic step(input bit chk);
        mreq_t e;
        bit    exp_req_valid, exp_out_valid, do_pop, accepted;
        @(negedge clk);
        reset             = rst;
        bus.IFreq_ready   = req_rdy;
        bus.IFout_ready   = out_rdy;
        bus.IFredirect    = redir;
        bus.IFredirect_pc = redir_pc;
        rsp_now           = !rst && (mem_q.size() > 0);
        if (rsp_now) rsp_now = (mem_q[0].due <= cyc);
        bus.IFrsp_valid   = rsp_now;
        bus.IFrsp_data    = 32'h0;
        if (rsp_now) bus.IFrsp_data = mem_word(mem_q[0].dut_addr);
        #1;
        cap_req_valid = bus.IFreq_valid;
        cap_req_addr  = bus.IFreq_addr;
        cap_out_valid = bus.IFout_valid;
        cap_out_pc    = bus.IFout_pc;
        cap_out_instr = bus.IFout_instr;
        exp_req_valid = !redir && ((exp_q.size() + mem_q.size()) < DEPTH);
        exp_out_valid = (exp_q.size() > 0);
        if (chk) begin
            if (rst) begin
                check("reset_req_valid", 32'(cap_req_valid), 32'd0);
                check("reset_out_valid", 32'(cap_out_valid), 32'd0);
                check("reset_out_instr", cap_out_instr, 32'd0);
                check("reset_out_pc", cap_out_pc, 32'd0);
`ifdef IFETCH_PERF_EN
                check("reset_perf_flushes", bus.IFperf_flushes, 32'd0);
                check("reset_perf_bubbles", bus.IFperf_bubbles, 32'd0);
`endif
            end else begin
                check("req_valid", 32'(cap_req_valid), 32'(exp_req_valid));
                if (exp_req_valid && cap_req_valid) check("req_addr", cap_req_addr, mdl_fetch_pc);
                check("out_valid", 32'(cap_out_valid), 32'(exp_out_valid));
                if (exp_out_valid && cap_out_valid) begin
                    check("out_pc", cap_out_pc, exp_q[0]);
                    check("out_instr", cap_out_instr, mem_word(exp_q[0]));
                end
`ifdef IFETCH_PERF_EN
                check("perf_flushes", bus.IFperf_flushes, 32'(n_flush));
                check("perf_bubbles", bus.IFperf_bubbles, 32'(n_bubble));
`endif
            end
        end
        @(posedge clk);
        if (rst) begin
            mem_q.delete();
            exp_q.delete();
            mdl_fetch_pc = 32'h0;
            last_due     = -1;
            n_flush      = 0;
            n_bubble     = 0;
        end else begin
            if (!exp_out_valid) n_bubble++;
            if (cap_out_valid && out_rdy && !redir) pop_log.push_back(cap_out_pc);
            do_pop = !redir && exp_out_valid && out_rdy;
            if (do_pop) void'(exp_q.pop_front());
            if (rsp_now) begin
                e = mem_q.pop_front();
                if (!redir && !e.stale) exp_q.push_back(e.mdl_pc);
            end
            // Memory accepts whatever the DUT actually presents.
            accepted = cap_req_valid && req_rdy;
            if (accepted) begin
                e.dut_addr = cap_req_addr;
                e.mdl_pc   = mdl_fetch_pc;
                e.due      = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                e.stale    = 1'b0;
                last_due   = e.due;
                mem_q.push_back(e);
                acc_cnt++;
                last_acc_addr = cap_req_addr;
            end
            if (redir) begin
                exp_q.delete();
                foreach (mem_q[i]) mem_q[i].stale = 1'b1;
                mdl_fetch_pc = {redir_pc[31:2], 2'b00};
                n_flush++;
            end else if (accepted) begin
                mdl_fetch_pc = mdl_fetch_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0);
        step(1'b1);
        rst = 1'b0;
        pop_log.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int          first_valid;
        logic [31:0] first_instr, first_pc;
        bit          found;

        vectors = 0; miscompares = 0; cyc = 0; last_due = -1; lat = 1;
        acc_cnt = 0; n_flush = 0; n_bubble = 0; last_acc_addr = 32'h0;
        rst = 1'b1; req_rdy = 1'b1; out_rdy = 1'b1; redir = 1'b0; redir_pc = 32'h0;
        reset = 1'b1; bus.IFreq_ready = 1'b0; bus.IFrsp_valid = 1'b0; bus.IFrsp_data = 32'h0;
        bus.IFout_ready = 1'b0; bus.IFredirect = 1'b0; bus.IFredirect_pc = 32'h0;

        // Streaming with 1-cycle memory and an always-ready decoder.
        do_reset();
        first_valid = -1;
        first_instr = 32'h0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1);
            if (first_valid < 0 && cap_out_valid) begin
                first_valid = i;
                first_instr = cap_out_instr;
            end
        end
        check("p1_first_valid_cycle", 32'(first_valid), 32'd2);
        check("p1_first_instr", first_instr, 32'hC0DE_0013);
        check("p1_pop0_pc", log_at(0), 32'h0);
        check("p1_pop1_pc", log_at(1), 32'h4);
        check("p1_pop2_pc", log_at(2), 32'h8);

        // Decoder stalled: exactly DEPTH requests, then the head holds.
        do_reset();
        out_rdy = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 10; i++) step(1'b1);
        check("p2_requests", 32'(acc_cnt), 32'd4);
        check("p2_req_valid_low", 32'(cap_req_valid), 32'd0);
        check("p2_head_pc", cap_out_pc, 32'h0);
        check("p2_head_instr", cap_out_instr, 32'hC0DE_0013);

        // Latency 3, redirect to 0x103 with two requests in flight.
        lat = 3;
        out_rdy = 1'b1;
        for (int i = 0; i < 20 && mem_q.size() != 2; i++) step(1'b1);
        check("p3_setup_inflight", 32'(mem_q.size()), 32'd2);
        redir = 1'b1; redir_pc = 32'h0000_0103;
        step(1'b1);
        redir = 1'b0;
        acc_cnt = 0;
        last_acc_addr = 32'hDEAD_BEEF;
        for (int i = 0; i < 10 && acc_cnt == 0; i++) step(1'b1);
        check("p3_next_addr", last_acc_addr, 32'h0000_0100);
        first_pc = 32'hDEAD_BEEF;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1);
            if (cap_out_valid) begin
                found = 1'b1;
                first_pc = cap_out_pc;
            end
        end
        check("p3_first_pc", first_pc, 32'h0000_0100);

        // Response, redirect and pop attempt in one cycle.
        lat = 2;
        out_rdy = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (mem_q.size() > 0 && exp_q.size() > 0 && mem_q[0].due <= cyc) found = 1'b1;
            else step(1'b1);
        end
        check("p4_setup_found", 32'(found), 32'd1);
        redir = 1'b1; redir_pc = 32'h0000_0200; out_rdy = 1'b1;
        step(1'b1);
        redir = 1'b0;
        step(1'b1);
        check("p4_empty_after_flush", 32'(cap_out_valid), 32'd0);
        first_pc = 32'hDEAD_BEEF;
        first_instr = 32'hDEAD_BEEF;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1);
            if (cap_out_valid) begin
                found = 1'b1;
                first_pc = cap_out_pc;
                first_instr = cap_out_instr;
            end
        end
        check("p4_first_pc", first_pc, 32'h0000_0200);
        check("p4_first_instr", first_instr, 32'hC0DE_0213);

        // PC wrap at the top of the address space.
        lat = 1;
        redir = 1'b1; redir_pc = 32'hFFFF_FFFA;
        step(1'b1);
        redir = 1'b0;
        pop_log.delete();
        for (int i = 0; i < 10; i++) step(1'b1);
        check("p5_wrap_pc0", log_at(0), 32'hFFFF_FFF8);
        check("p5_wrap_pc1", log_at(1), 32'hFFFF_FFFC);
        check("p5_wrap_pc2", log_at(2), 32'h0000_0000);

        // Random memory and decode backpressure over 200 instructions.
        pop_log.delete();
        for (int i = 0; i < 4000 && pop_log.size() < 200; i++) begin
            req_rdy = 1'($urandom_range(0, 1));
            out_rdy = 1'($urandom_range(0, 1));
            lat     = int'($urandom_range(1, 3));
            step(1'b1);
        end
        req_rdy = 1'b1;
        out_rdy = 1'b1;
        lat = 1;
        check("p6_pop_count_reached", 32'(pop_log.size() >= 200), 32'd1);
        for (int i = 1; i < pop_log.size(); i++) begin
            check("p6_sequential_pc", pop_log[i], pop_log[i-1] + 32'd4);
        end

`ifdef IFETCH_PERF_EN
        // Three back-to-back redirects right after reset, then let one word arrive.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            redir = 1'b1; redir_pc = 32'h40 * (i + 1);
            step(1'b1);
        end
        redir = 1'b0;
        step(1'b1);
        step(1'b1);
        step(1'b1);
        check("p7_out_valid", 32'(cap_out_valid), 32'd1);
        check("p7_perf_flushes", bus.IFperf_flushes, 32'd3);
        check("p7_perf_bubbles", bus.IFperf_bubbles, 32'd5);
        step(1'b1);
        do_reset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction fetch stage sitting directly upstream of the control unit/decoder.
- Issues sequential word fetches to instruction memory over a request/response handshake and buffers returned words with their PC tags in a small prefetch queue.
- Presents one instruction per cycle to decode with valid/ready.
- On a branch/jump redirect, flushes the queue and discards any responses still in flight.

Parameters:
- DEPTH, 4: prefetch queue entries; also the cap on queued plus in-flight fetches. Power of two, at least 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- IFreq_valid  out  1  fetch request valid
- IFreq_addr  out  32  fetch word address, bits[1:0]=0
- IFreq_ready  in  1  memory accepts request this cycle
- IFrsp_valid  in  1  response word valid; responses in request order, latency >=1 cycle, at most one per cycle
- IFrsp_data  in  32  fetched instruction word
- IFout_valid  out  1  instruction available to decode
- IFout_instr  out  32  instruction at queue head
- IFout_pc  out  32  PC of IFout_instr
- IFout_ready  in  1  decode consumes head this cycle
- IFredirect  in  1  taken branch/jump, flush
- IFredirect_pc  in  32  new fetch PC, bits[1:0] ignored (forced 0)

Behaviour:
- Interface: one clock; reset is synchronous and active-high; ports named clk and reset.
- Reset state:
  - fetch_pc=RESET_PC, rsp_pc=RESET_PC.
  - count=0, inflight=0, discard=0.
  - IFreq_valid=0, IFout_valid=0, IFout_instr=0, IFout_pc=0.
  - Reset overrides every other input in the same cycle, including redirect.
- Request issue:
  - IFreq_valid=1 when (count+inflight)<DEPTH and IFredirect=0.
  - IFreq_addr=fetch_pc.
  - On IFreq_valid&&IFreq_ready: fetch_pc+=4 (32-bit wrap from 32'hFFFF_FFFC to 0); inflight+1.
  - inflight counts every accepted request whose response has not yet returned, including requests marked for discard. This credit rule guarantees the queue never overflows.
- Response handling:
  - On IFrsp_valid: inflight-1.
  - If discard>0: drop the word, discard-1.
  - Otherwise push {rsp_pc, IFrsp_data} into the queue; rsp_pc+=4.
- Output:
  - IFout_valid=(count>0); head fields are driven from registered queue storage.
  - A response reaches IFout at the earliest on the cycle after IFrsp_valid; there is no bypass.
  - Pop on IFout_valid&&IFout_ready.
  - Push and pop in the same cycle are allowed at any occupancy; count stays unchanged.
  - IFout_instr/IFout_pc hold their values while IFout_ready=0.
- Redirect (IFredirect=1):
  - Queue cleared, count=0. Any pop in that cycle is ignored; flush wins.
  - fetch_pc=rsp_pc={IFredirect_pc[31:2],2'b00}.
  - IFreq_valid forced 0 in the redirect cycle.
  - A response arriving in the redirect cycle is dropped.
  - discard=inflight after that cycle's response decrement.
  - Fetching resumes the next cycle.
  - Back-to-back redirects: the last one wins; discard recomputed each time.
- Stall/backpressure:
  - IFreq_ready=0 holds IFreq_valid/IFreq_addr stable unless a redirect occurs.
  - A redirect may withdraw an unaccepted request.
- Counters (count, inflight, discard) are sized clog2(DEPTH)+1 bits. Invariant: count+inflight<=DEPTH.

Optional Feature:
- Macro IFETCH_PERF_EN.
- Defined: adds outputs IFperf_flushes (32) and IFperf_bubbles (32).
  - IFperf_flushes increments on each redirect.
  - IFperf_bubbles increments on each cycle with IFout_valid=0 and no reset.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - XLEN=32, INSTR_W=32, PC_STEP=4.
  - Default RESET_PC.
  - NOP encoding 32'h0000_0013 (for decode-side bubbles).
  - Queue entry typedef {pc, instr}.
- One sub-module, if_fifo: synchronous DEPTH-entry FIFO with push, pop, flush, count, registered head.
- Counters and redirect logic stay in ifetch_queue.

Test Plan:
- Reset, memory with 1-cycle latency, IFout_ready=1 → requests 0x0,0x4,0x8,…; IFout_pc 0x0 first valid on cycle 3 after reset release, then one instruction per cycle in order.
- IFout_ready=0 for 10 cycles, memory always ready → exactly DEPTH=4 requests issued; IFreq_valid then low; count=4; IFout holds pc 0x0 stable.
- Memory latency 3, redirect to 0x103 with 2 requests in flight → next request addr 0x100; both old responses dropped; first IFout_pc=0x100.
- Response and redirect in the same cycle, plus pop attempt → response dropped, queue empty next cycle, no double pop, discard equals remaining inflight.
- IFreq_ready toggling randomly over 200 instructions with random IFout_ready → IFout_pc strictly +4 sequential, no loss or duplication, count+inflight never exceeds 4.
- With IFETCH_PERF_EN, 3 redirects and 5 empty cycles → IFperf_flushes=3, IFperf_bubbles=5; reset → both 0.
